// File: rtl/mig_pkg.sv
// Shared types and default sizing for the sequential MIG evaluator.
// The MIG_COMPL_EDGE_EN build macro is consumed by mig_seq_eval, not here.
package mig_pkg;

    localparam int MIG_N_IN    = 7;
    localparam int MIG_N_NODES = 8;

    // Operand select width: const0, every primary input, every node.
    function automatic int mig_selw(input int n_in, input int n_nodes);
        return $clog2(1 + n_in + n_nodes);
    endfunction

    localparam int MIG_SELW = mig_selw(MIG_N_IN, MIG_N_NODES);

    typedef logic [MIG_SELW-1:0] mig_sel_t;

    typedef struct packed {
        mig_sel_t [2:0] sel;
        logic     [2:0] compl;
    } mig_node_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } mig_state_e;

endpackage

// File: rtl/mig_seq_eval_if.sv
// Config, input-vector and result streams of mig_seq_eval bundled as one interface.
interface mig_seq_eval_if
    import mig_pkg::*;
#(
    parameter int N_IN    = MIG_N_IN,
    parameter int N_NODES = MIG_N_NODES
);
    localparam int SELW = mig_selw(N_IN, N_NODES);
    localparam int AW   = $clog2(N_NODES);

    logic                    cfg_we;
    logic                    cfg_ready;
    logic [AW-1:0]           cfg_addr;
    logic [3*(SELW+1)-1:0]   cfg_node;
    logic [AW:0]             cfg_out;
    logic                    cfg_out_we;
    logic                    in_valid;
    logic                    in_ready;
    logic [N_IN-1:0]         in_x;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_y;
    logic [N_NODES-1:0]      out_nodes;

    modport master (
        output cfg_we, cfg_addr, cfg_node, cfg_out, cfg_out_we,
        output in_valid, in_x, out_ready,
        input  cfg_ready, in_ready, out_valid, out_y, out_nodes
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_node, cfg_out, cfg_out_we,
        input  in_valid, in_x, out_ready,
        output cfg_ready, in_ready, out_valid, out_y, out_nodes
    );

endinterface

// File: rtl/mig_maj3.sv
// Three-input majority gate with per-operand optional inversion.
module mig_maj3 (
    input  logic [2:0] op,
    input  logic [2:0] inv,
    output logic       y
);
    logic [2:0] a;

    assign a = op ^ inv;
    assign y = (a[0] & a[1]) | (a[0] & a[2]) | (a[1] & a[2]);

endmodule

// File: rtl/mig_seq_eval.sv
// Programmable MIG evaluator: loadable node table, one majority node per cycle.
// Build macro MIG_COMPL_EDGE_EN enables complemented edges and output inversion.
module mig_seq_eval
    import mig_pkg::*;
#(
    parameter int N_IN    = MIG_N_IN,
    parameter int N_NODES = MIG_N_NODES
) (
    input  logic           clk,
    input  logic           rst_n,
    mig_seq_eval_if.slave  bus
);
    localparam int SELW  = mig_selw(N_IN, N_NODES);
    localparam int AW    = $clog2(N_NODES);
    localparam int NW    = 3 * (SELW + 1);
    localparam int SRC_W = 1 + N_IN + N_NODES;
    localparam int SRC_N = 1 << SELW;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_EVAL = EVAL;
    localparam logic [1:0] S_DONE = DONE;

`ifdef MIG_COMPL_EDGE_EN
    localparam logic COMPL_EN = 1'b1;
`else
    // Complement bits stay in the table but are masked to constant 0 here.
    localparam logic COMPL_EN = 1'b0;
`endif

    logic [1:0]          state;
    logic [AW-1:0]       idx;
    logic [N_IN-1:0]     x_q;
    logic [N_NODES-1:0]  node_q;
    logic [NW-1:0]       table_q [N_NODES];
    logic [AW-1:0]       out_node_q;
    logic                out_compl_q;
    logic                out_y_q;

    logic [NW-1:0]       cur;
    logic [SRC_N-1:0]    src;
    logic [2:0]          op;
    logic [2:0]          inv;
    logic                maj_y;
    logic [N_NODES-1:0]  node_next;

    // Operand space: bit 0 is const0, then inputs, then node registers;
    // selects past the last node land in the zero padding.
    always_comb begin
        cur = table_q[idx];
        src = '0;
        src[SRC_W-1:0] = {node_q, x_q, 1'b0};
        op  = '0;
        inv = '0;
        for (int j = 0; j < 3; j++) begin
            op[j]  = src[cur[j*(SELW+1) +: SELW]];
            inv[j] = cur[j*(SELW+1) + SELW] & COMPL_EN;
        end
        node_next      = node_q;
        node_next[idx] = maj_y;
    end

    mig_maj3 u_maj3 (
        .op  (op),
        .inv (inv),
        .y   (maj_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            x_q         <= '0;
            node_q      <= '0;
            out_node_q  <= '0;
            out_compl_q <= 1'b0;
            out_y_q     <= 1'b0;
            // NOTE: the node table is small and must read back as zero after reset, so it is reset like plain flops.
            for (int k = 0; k < N_NODES; k++) table_q[k] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cfg_we && (int'(bus.cfg_addr) < N_NODES))
                        table_q[bus.cfg_addr] <= bus.cfg_node;
                    if (bus.cfg_out_we) begin
                        out_compl_q <= bus.cfg_out[AW];
                        out_node_q  <= bus.cfg_out[AW-1:0];
                    end
                    if (bus.in_valid) begin
                        x_q    <= bus.in_x;
                        node_q <= '0;
                        idx    <= '0;
                        state  <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    node_q[idx] <= maj_y;
                    if (idx == AW'(N_NODES - 1)) begin
                        out_y_q <= node_next[out_node_q] ^ (out_compl_q & COMPL_EN);
                        state   <= S_DONE;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.cfg_ready = (state == S_IDLE);
    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.out_y     = out_y_q;
    assign bus.out_nodes = node_q;

endmodule

// File: tb/tb_mig_seq_eval.sv
// Randomized self-checking bench for mig_seq_eval against a node-by-node MIG model.
// Honours MIG_COMPL_EDGE_EN the same way the design build does.
module tb_mig_seq_eval;
    import mig_pkg::*;

    localparam int N_IN    = MIG_N_IN;
    localparam int N_NODES = MIG_N_NODES;
    localparam int SELW    = MIG_SELW;
    localparam int AW      = $clog2(N_NODES);
`ifdef MIG_COMPL_EDGE_EN
    localparam bit COMPL_EN = 1'b1;
`else
    localparam bit COMPL_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mig_seq_eval_if bus ();

    mig_seq_eval dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    mig_node_t m_tab [N_NODES];
    int        m_out_node;
    bit        m_out_cmp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic mig_node_t mk(input int s0, input int s1, input int s2, input logic [2:0] c);
        mig_node_t n;
        n.sel[0] = mig_sel_t'(s0);
        n.sel[1] = mig_sel_t'(s1);
        n.sel[2] = mig_sel_t'(s2);
        n.compl  = c;
        return n;
    endfunction

    function automatic logic [3*(SELW+1)-1:0] pack_node(input mig_node_t n);
        return {n.compl[2], n.sel[2], n.compl[1], n.sel[1], n.compl[0], n.sel[0]};
    endfunction

    // Reference: nodes start at 0 each evaluation and are filled in index order;
    // a node is 1 when at least two of its (possibly inverted) operands are 1.
    function automatic void model_eval(input logic [N_IN-1:0] x, output logic y,
                                       output logic [N_NODES-1:0] v);
        int s, cnt;
        bit b;
        v = '0;
        for (int k = 0; k < N_NODES; k++) begin
            cnt = 0;
            for (int j = 0; j < 3; j++) begin
                s = int'(m_tab[k].sel[j]);
                if (s == 0)                    b = 1'b0;
                else if (s <= N_IN)            b = x[s-1];
                else if (s <= N_IN + N_NODES)  b = v[s-N_IN-1];
                else                           b = 1'b0;
                if (COMPL_EN) b = b ^ m_tab[k].compl[j];
                cnt += int'(b);
            end
            v[k] = (cnt >= 2);
        end
        y = v[m_out_node] ^ (COMPL_EN & m_out_cmp);
    endfunction

    task automatic reset_model();
        for (int k = 0; k < N_NODES; k++) m_tab[k] = mk(0, 0, 0, 3'b000);
        m_out_node = 0;
        m_out_cmp  = 1'b0;
    endtask

    task automatic cfg_write(input int a, input mig_node_t n);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(a);
        bus.cfg_node = pack_node(n);
        @(negedge clk);
        bus.cfg_we   = 1'b0;
        m_tab[a]     = n;
    endtask

    task automatic set_out(input int node, input bit cmp);
        bus.cfg_out_we = 1'b1;
        bus.cfg_out    = {cmp, AW'(node)};
        @(negedge clk);
        bus.cfg_out_we = 1'b0;
        m_out_node     = node;
        m_out_cmp      = cmp;
    endtask

    task automatic load_t2();
        cfg_write(0, mk(1, 2, 3, 3'b000));
        cfg_write(1, mk(1, 3, 7, 3'b000));
        cfg_write(2, mk(1, 5, 6, 3'b000));
        cfg_write(3, mk(2, 4, 9, 3'b000));
        cfg_write(4, mk(8, 10, 11, 3'b000));
        for (int k = 5; k < N_NODES; k++) cfg_write(k, mk(0, 0, 0, 3'b000));
        set_out(4, 1'b0);
    endtask

    // Entered on the negedge right after the accept edge; ends idle on a negedge.
    task automatic finish_vec(input string tag, input logic ey, input logic [N_NODES-1:0] ev,
                              input int max_stall, output logic y, output logic [N_NODES-1:0] v);
        int lat;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 4 * N_NODES) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, N_NODES + 1);
        repeat ($urandom_range(0, max_stall)) @(negedge clk);
        check({tag, ".valid"}, bus.out_valid, 1'b1);
        check({tag, ".y"}, bus.out_y, ey);
        check({tag, ".nodes"}, bus.out_nodes, ev);
        y = bus.out_y;
        v = bus.out_nodes;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, ".drained"}, bus.out_valid, 1'b0);
    endtask

    task automatic run_vec(input string tag, input logic [N_IN-1:0] x, input int max_stall,
                           output logic y, output logic [N_NODES-1:0] v);
        logic               ey;
        logic [N_NODES-1:0] ev;
        model_eval(x, ey, ev);
        check({tag, ".in_ready"}, bus.in_ready, 1'b1);
        bus.in_x     = x;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        finish_vec(tag, ey, ev, max_stall, y, v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic               y, ey;
        logic [N_NODES-1:0] v, ev;
        int                 lat;

        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_node = '0;
        bus.cfg_out = '0;  bus.cfg_out_we = 1'b0;
        bus.in_valid = 1'b0; bus.in_x = '0; bus.out_ready = 1'b0;
        reset_model();

        repeat (2) @(negedge clk);
        check("rst.out_valid", bus.out_valid, 1'b0);
        check("rst.out_y", bus.out_y, 1'b0);
        check("rst.out_nodes", bus.out_nodes, '0);
        check("rst.in_ready", bus.in_ready, 1'b1);
        check("rst.cfg_ready", bus.cfg_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // Reference net: n4 = MAJ(n0, n2, n3).
        load_t2();
        run_vec("t2", 7'b0000111, 0, y, v);
        check("t2.y_const", y, 1'b1);
        check("t2.nodes_const", v[4:0], 5'b11011);
        run_vec("t3a", 7'b0000001, 2, y, v);
        check("t3a.y_const", y, 1'b0);
        run_vec("t3b", 7'b0111011, 2, y, v);
        check("t3b.y_const", y, 1'b1);
        check("t3b.nodes_const", v[4:0], 5'b11101);

        // Result held for 10 stalled cycles; config strobes in that window must be dropped.
        model_eval(7'b0000111, ey, ev);
        bus.in_x = 7'b0000111; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 4 * N_NODES) begin
            @(negedge clk);
            lat++;
        end
        check("t4.latency", lat, N_NODES + 1);
        for (int c = 0; c < 10; c++) begin
            bus.cfg_we     = (c % 3 == 1);
            bus.cfg_addr   = AW'(4);
            bus.cfg_node   = pack_node(mk(0, 0, 0, 3'b000));
            bus.cfg_out_we = (c % 3 == 1);
            bus.cfg_out    = {1'b1, AW'(0)};
            @(negedge clk);
            check("t4.y_hold", bus.out_y, ey);
            check("t4.in_ready", bus.in_ready, 1'b0);
            check("t4.cfg_ready", bus.cfg_ready, 1'b0);
        end
        bus.cfg_we = 1'b0; bus.cfg_out_we = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        run_vec("t4.after", 7'b0000111, 1, y, v);
        check("t4.after_y_const", y, 1'b1);

        // A write in the accept cycle lands before evaluation starts.
        bus.cfg_we = 1'b1; bus.cfg_addr = AW'(4);
        bus.cfg_node = pack_node(mk(0, 0, 0, 3'b000));
        bus.in_x = 7'b0000111; bus.in_valid = 1'b1;
        m_tab[4] = mk(0, 0, 0, 3'b000);
        model_eval(7'b0000111, ey, ev);
        @(negedge clk);
        bus.cfg_we = 1'b0; bus.in_valid = 1'b0;
        finish_vec("wr_accept", ey, ev, 0, y, v);
        check("wr_accept.y_const", y, 1'b0);
        check("wr_accept.nodes_const", v, 8'h0B);

        // Reset in the middle of an evaluation, three nodes in.
        load_t2();
        bus.in_x = 7'b0000111; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t1.partial_nodes", bus.out_nodes, 8'b0000_0011);
        rst_n = 1'b0;
        #1;
        check("t1.out_valid", bus.out_valid, 1'b0);
        check("t1.in_ready", bus.in_ready, 1'b1);
        check("t1.cfg_ready", bus.cfg_ready, 1'b1);
        check("t1.out_nodes", bus.out_nodes, '0);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        @(negedge clk);
        run_vec("t1.after", 7'($urandom), 0, y, v);
        check("t1.after_y_const", y, 1'b0);
        check("t1.after_nodes_const", v, '0);

        // Complemented constants and output inversion only count with the macro.
        cfg_write(0, mk(0, 0, 1, 3'b011));
        cfg_write(1, mk(1, 0, 0, 3'b010));
        set_out(1, 1'b1);
        for (int b = 0; b < 2; b++) begin
            run_vec("t5", {6'($urandom), b[0]}, 1, y, v);
            check("t5.n0", v[0], COMPL_EN);
            check("t5.n1", v[1], COMPL_EN & b[0]);
            check("t5.y", y, COMPL_EN & ~b[0]);
        end

        // Exhaustive sweep of the reference net with random result stalls.
        load_t2();
        for (int i = 0; i < (1 << N_IN); i++) run_vec("t6", 7'(i), 3, y, v);

        // Random tables, including forward and self references.
        for (int t = 0; t < 16; t++) begin
            for (int k = 0; k < N_NODES; k++)
                cfg_write(k, mk($urandom_range(0, (1 << SELW) - 1), $urandom_range(0, (1 << SELW) - 1),
                                $urandom_range(0, (1 << SELW) - 1), 3'($urandom)));
            set_out($urandom_range(0, N_NODES - 1), 1'($urandom));
            for (int i = 0; i < 6; i++) run_vec("rnd", 7'($urandom), 2, y, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
